game_tick_sequencer: RTL and testbench

//  Paces the snake game once mode_control has entered GAME.
//  - Runs a start countdown.
//  - Then issues one board step per tick.
//  - Each tick exchanges the local direction with the remote board over the

---
 rtl/snake_pkg.sv | 32 +++
 rtl/game_tick_sequencer_if.sv | 15 +
 rtl/cycle_timer.sv | 25 ++
 rtl/game_tick_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_game_tick_sequencer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game types, sequencer states and default timing constants.
package snake_pkg;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

  typedef enum logic [1:0] {MODE_MENU, MODE_GAME, MODE_WIN, MODE_LOSE} game_mode;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_WAIT_TICK,
    S_SEND,
    S_WAIT_REMOTE,
    S_STEP,
    S_HALT
  } seq_state_t;

  localparam int TICK_CYCLES_DEF    = 9_375_000;
  localparam int COUNT_START_DEF    = 3;
  localparam int COUNT_CYCLES_DEF   = 75_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 37_500_000;

  // One bit of headroom above the largest reload value.
  function automatic int timer_width(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/game_tick_sequencer_if.sv
// Move-exchange link between the tick sequencer and the remote-board transport.
interface game_tick_sequencer_if;
  import snake_pkg::*;

  logic tx_valid;
  logic tx_ready;
  dir_t tx_data;
  logic rx_valid;
  dir_t rx_data;

  modport master (output tx_valid, output tx_data, input tx_ready,
                  input rx_valid, input rx_data);
  modport slave  (input tx_valid, input tx_data, output tx_ready,
                  output rx_valid, output rx_data);
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter that holds at zero; expired is high while it reads zero.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_75,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk_75) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - WIDTH'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/game_tick_sequencer.sv
// Paces the snake game: start countdown, then one board step per tick once the
// local and remote moves for that tick are both known.
module game_tick_sequencer
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES    = TICK_CYCLES_DEF,
  parameter int COUNT_START    = COUNT_START_DEF,
  parameter int COUNT_CYCLES   = COUNT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                   clk_75,
  input  logic                   rst,
  input  game_mode               mode,
  input  dir_t                   dir_local,
  game_tick_sequencer_if.master  link,
  output logic                   step,
  output dir_t                   dir_p1,
  output dir_t                   dir_p2,
  output logic [1:0]             countdown,
  output logic                   con_error
);

  localparam int TW = timer_width(TICK_CYCLES, COUNT_CYCLES, TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TICK_LOAD    = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] COUNT_LOAD   = TW'(COUNT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

  seq_state_t  state, state_n;
  logic        tx_valid_q, tx_valid_n;
  dir_t        tx_data_q, tx_data_n;
  dir_t        dir_p1_q, dir_p1_n;
  dir_t        dir_p2_q, dir_p2_n;
  logic [1:0]  cd_q, cd_n;
  logic        err_q, err_n;
  logic        rx_flag_q, rx_flag_n;
  dir_t        rx_data_q, rx_data_n;

  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expired;
  logic          have_rx;
  dir_t          rx_move;
  logic          go_step;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk_75  (clk_75),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk_75) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= DIR_RIGHT;
      dir_p1_q   <= DIR_RIGHT;
      dir_p2_q   <= DIR_RIGHT;
      cd_q       <= 2'd0;
      err_q      <= 1'b0;
      rx_flag_q  <= 1'b0;
      rx_data_q  <= DIR_RIGHT;
    end else begin
      state      <= state_n;
      tx_valid_q <= tx_valid_n;
      tx_data_q  <= tx_data_n;
      dir_p1_q   <= dir_p1_n;
      dir_p2_q   <= dir_p2_n;
      cd_q       <= cd_n;
      err_q      <= err_n;
      rx_flag_q  <= rx_flag_n;
      rx_data_q  <= rx_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    tx_valid_n = tx_valid_q;
    tx_data_n  = tx_data_q;
    dir_p1_n   = dir_p1_q;
    dir_p2_n   = dir_p2_q;
    cd_n       = cd_q;
    err_n      = err_q;
    rx_flag_n  = rx_flag_q;
    rx_data_n  = rx_data_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    go_step    = 1'b0;
    // A move arriving this very cycle counts as latched.
    have_rx    = rx_flag_q | link.rx_valid;
    rx_move    = rx_flag_q ? rx_data_q : link.rx_data;

    if (mode != MODE_GAME) begin
      state_n    = S_IDLE;
      tx_valid_n = 1'b0;
      tx_data_n  = DIR_RIGHT;
      dir_p1_n   = DIR_RIGHT;
      dir_p2_n   = DIR_RIGHT;
      cd_n       = 2'd0;
      err_n      = 1'b0;
      rx_flag_n  = 1'b0;
      rx_data_n  = DIR_RIGHT;
      tmr_load   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_n   = S_COUNTDOWN;
          cd_n      = 2'(COUNT_START);
          tmr_load  = 1'b1;
          tmr_value = COUNT_LOAD;
        end
        S_COUNTDOWN: begin
          if (tmr_expired) begin
            tmr_load = 1'b1;
            if (cd_q <= 2'd1) begin
              cd_n      = 2'd0;
              state_n   = S_WAIT_TICK;
              tmr_value = TICK_LOAD;
            end else begin
              cd_n      = cd_q - 2'd1;
              tmr_value = COUNT_LOAD;
            end
          end
        end
        S_WAIT_TICK, S_SEND, S_WAIT_REMOTE: begin
          if (link.rx_valid && !rx_flag_q) begin
            rx_flag_n = 1'b1;
            rx_data_n = link.rx_data;
          end
          // A second remote move before we consumed the first: remote ran ahead.
          if (link.rx_valid && rx_flag_q) begin
            state_n    = S_HALT;
            err_n      = 1'b1;
            tx_valid_n = 1'b0;
          end else if (state == S_WAIT_TICK) begin
            if (tmr_expired) begin
              tx_data_n  = dir_local;
              tx_valid_n = 1'b1;
              state_n    = S_SEND;
            end
          end else if (state == S_SEND) begin
            if (tx_valid_q && link.tx_ready) begin
              tx_valid_n = 1'b0;
              if (have_rx) begin
                go_step = 1'b1;
              end else begin
                state_n   = S_WAIT_REMOTE;
                tmr_load  = 1'b1;
                tmr_value = TIMEOUT_LOAD;
              end
            end
          end else begin
            if (have_rx) begin
              go_step = 1'b1;
            end else if (tmr_expired) begin
              state_n = S_HALT;
              err_n   = 1'b1;
            end
          end
        end
        S_STEP: begin
          rx_flag_n = 1'b0;
          state_n   = S_WAIT_TICK;
        end
        S_HALT: begin
          state_n = S_HALT;
        end
        default: state_n = S_IDLE;
      endcase

      // The tick period starts with the step cycle itself.
      if (go_step) begin
        state_n   = S_STEP;
        dir_p1_n  = tx_data_q;
        dir_p2_n  = rx_move;
        tmr_load  = 1'b1;
        tmr_value = TICK_LOAD;
      end
    end
  end

  assign link.tx_valid = tx_valid_q;
  assign link.tx_data  = tx_data_q;
  assign step          = (state == S_STEP);
  assign dir_p1        = dir_p1_q;
  assign dir_p2        = dir_p2_q;
  assign countdown     = cd_q;
  assign con_error     = err_q;

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Directed bench for game_tick_sequencer with a timestamp-based reference model.
module tb_game_tick_sequencer;
  import snake_pkg::*;

  localparam int TICK = 20;
  localparam int CS   = 2;
  localparam int CC   = 10;
  localparam int TO   = 8;

  logic       clk_75 = 1'b0;
  logic       rst;
  game_mode   mode;
  dir_t       dir_local;
  logic       step;
  dir_t       dir_p1;
  dir_t       dir_p2;
  logic [1:0] countdown;
  logic       con_error;

  game_tick_sequencer_if link();

  game_tick_sequencer #(
    .TICK_CYCLES    (TICK),
    .COUNT_START    (CS),
    .COUNT_CYCLES   (CC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_75    (clk_75),
    .rst       (rst),
    .mode      (mode),
    .dir_local (dir_local),
    .link      (link),
    .step      (step),
    .dir_p1    (dir_p1),
    .dir_p2    (dir_p2),
    .countdown (countdown),
    .con_error (con_error)
  );

  always #5 clk_75 = ~clk_75;

  // Reference model: events are scheduled as absolute cycle numbers.
  int   cyc = 0;
  bit   m_active = 0, m_halt = 0, m_acc = 0, m_txv = 0, m_step = 0, m_err = 0;
  dir_t m_txd = DIR_RIGHT, m_p1 = DIR_RIGHT, m_p2 = DIR_RIGHT;
  int   m_cd = 0, cd_at = -1, tick_at = -1, dead_at = -1;
  dir_t rxq[$];

  always @(posedge clk_75) begin
    bit rx_ok;
    bit was_step;
    int was_cd;
    cyc++;
    was_step = m_step;
    was_cd   = m_cd;
    m_step   = 0;
    if (rst || mode != MODE_GAME) begin
      m_active = 0; m_halt = 0; m_acc = 0; m_txv = 0; m_err = 0;
      m_txd = DIR_RIGHT; m_p1 = DIR_RIGHT; m_p2 = DIR_RIGHT;
      m_cd = 0; cd_at = -1; tick_at = -1; dead_at = -1;
      rxq.delete();
    end else if (!m_active) begin
      m_active = 1;
      m_cd     = CS;
      cd_at    = cyc + CC;
      tick_at  = cyc + CS * CC + TICK;
    end else if (!m_halt) begin
      rx_ok = link.rx_valid && was_cd == 0 && !was_step;
      if (rx_ok && rxq.size() != 0) begin
        m_halt = 1; m_err = 1; m_txv = 0;
      end else begin
        if (rx_ok) rxq.push_back(link.rx_data);
        if (m_cd > 0 && cyc == cd_at) begin
          m_cd--;
          cd_at = cyc + CC;
        end
        if (m_txv && link.tx_ready) begin
          m_txv = 0; m_acc = 1; dead_at = cyc + TO;
        end
        if (cyc == tick_at) begin
          m_txv = 1; m_txd = dir_local;
        end
        if (m_acc && rxq.size() != 0) begin
          m_step = 1; m_p1 = m_txd; m_p2 = rxq.pop_front();
          m_acc = 0; tick_at = cyc + TICK;
        end else if (m_acc && cyc == dead_at) begin
          m_halt = 1; m_err = 1;
        end
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge clk_75);
    cmp("step",      step,          m_step);
    cmp("tx_valid",  link.tx_valid, m_txv);
    cmp("tx_data",   link.tx_data,  m_txd);
    cmp("dir_p1",    dir_p1,        m_p1);
    cmp("dir_p2",    dir_p2,        m_p2);
    cmp("countdown", countdown,     m_cd);
    cmp("con_error", con_error,     m_err);
  endtask

  task automatic wait_txv(input int max, output int n);
    n = 0;
    while (link.tx_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    cmp("tx_wait_bound", link.tx_valid, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1; mode = MODE_MENU; dir_local = DIR_LEFT;
    link.tx_ready = 1'b0; link.rx_valid = 1'b0; link.rx_data = DIR_UP;
    repeat (3) tick();
    cmp("rst_tx_valid",  link.tx_valid, 0);
    cmp("rst_countdown", countdown, 0);
    cmp("rst_dir_p1",    dir_p1, DIR_RIGHT);
    cmp("rst_tx_data",   link.tx_data, DIR_RIGHT);
    rst = 1'b0;
    tick();

    // Countdown and first tick
    mode = MODE_GAME;
    tick();            cmp("cd_start", countdown, 2);
    repeat (10) tick(); cmp("cd_one", countdown, 1);
    repeat (10) tick(); cmp("cd_zero", countdown, 0);
    wait_txv(40, n);   cmp("tick_after_countdown", n, 20);

    // Immediate accept, remote move three cycles later
    link.tx_ready = 1'b1; tick(); link.tx_ready = 1'b0;
    repeat (2) tick();
    link.rx_valid = 1'b1; link.rx_data = DIR_UP;
    tick();
    link.rx_valid = 1'b0;
    cmp("step_after_rx", step, 1);
    cmp("step_p1", dir_p1, DIR_LEFT);
    cmp("step_p2", dir_p2, DIR_UP);

    // Remote move early, delayed accept
    tick();
    link.rx_valid = 1'b1; link.rx_data = DIR_DOWN; dir_local = DIR_UP;
    tick();
    link.rx_valid = 1'b0;
    wait_txv(40, n);   cmp("tick_period", n, 18);
    repeat (5) begin
      cmp("send_hold_valid", link.tx_valid, 1);
      cmp("send_hold_data", link.tx_data, DIR_UP);
      tick();
    end
    link.tx_ready = 1'b1; tick(); link.tx_ready = 1'b0;
    cmp("step_after_accept", step, 1);
    cmp("step2_p1", dir_p1, DIR_UP);
    cmp("step2_p2", dir_p2, DIR_DOWN);

    // Remote timeout
    dir_local = DIR_DOWN;
    wait_txv(40, n);
    link.tx_ready = 1'b1; tick(); link.tx_ready = 1'b0;
    n = 0;
    while (con_error !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    cmp("timeout_cycles", n, 8);
    repeat (5) tick();
    cmp("err_sticky", con_error, 1);
    mode = MODE_WIN;
    tick();
    cmp("win_err_clear", con_error, 0);
    cmp("win_countdown", countdown, 0);
    cmp("win_dir_p1", dir_p1, DIR_RIGHT);
    cmp("win_tx_data", link.tx_data, DIR_RIGHT);

    // Ignored rx during countdown, then remote two moves ahead
    mode = MODE_GAME;
    repeat (4) tick();
    link.rx_valid = 1'b1; link.rx_data = DIR_LEFT;
    tick();
    link.rx_valid = 1'b0;
    cmp("cd_rx_ignored", con_error, 0);
    wait_txv(60, n);
    link.rx_valid = 1'b1; link.rx_data = DIR_UP;
    tick();
    link.rx_valid = 1'b0;
    tick();
    link.rx_valid = 1'b1; link.rx_data = DIR_DOWN;
    tick();
    link.rx_valid = 1'b0;
    cmp("dup_rx_err", con_error, 1);
    tick();
    cmp("dup_rx_no_step", step, 0);
    mode = MODE_MENU;
    tick();

    // Abort from SEND by reset, then by leaving GAME
    mode = MODE_GAME;
    wait_txv(60, n);
    rst = 1'b1;
    tick();
    cmp("rst_send_tx_valid", link.tx_valid, 0);
    cmp("rst_send_countdown", countdown, 0);
    rst = 1'b0;
    tick();
    cmp("restart_cd_rst", countdown, 2);
    wait_txv(60, n);
    mode = MODE_MENU;
    tick();
    cmp("menu_send_tx_valid", link.tx_valid, 0);
    mode = MODE_GAME;
    tick();
    cmp("restart_cd_menu", countdown, 2);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
